// File: rtl/pep_batch_sched.sv
// PBS slot allocator and batch scheduler: hands out free slot ids, queues them in
// allocation order, and issues them to the PBS pipe in batches, one batch in flight.
module pep_batch_sched #(
    parameter int TOTAL_PBS_NB = 27,
    parameter int BATCH_PBS_NB = 18,
    parameter int GRAM_NB      = 3,
    parameter int TIMEOUT      = 64,
    localparam int PID_W = $clog2(TOTAL_PBS_NB),
    localparam int GID_W = $clog2(GRAM_NB),
    localparam int CNT_W = $clog2(TOTAL_PBS_NB + 1)
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             req_vld,
    output logic             req_rdy,
    output logic [PID_W-1:0] req_pid,
    output logic             bid_vld,
    input  logic             bid_rdy,
    output logic [PID_W-1:0] bid_pid,
    output logic [GID_W-1:0] bid_gid,
    output logic             bid_last,
    input  logic             batch_done,
    input  logic             rel_vld,
    input  logic [PID_W-1:0] rel_pid,
    input  logic             flush,
    output logic [CNT_W-1:0] free_cnt,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             rel_err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t                  state;
    logic [TOTAL_PBS_NB-1:0] free_map;
    logic [TOTAL_PBS_NB-1:0] pend_map;
    logic [PID_W-1:0]        fifo_mem [TOTAL_PBS_NB];
    logic [PID_W-1:0]        wr_ptr;
    logic [PID_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        bsize;
    logic [CNT_W-1:0]        pos;
    logic [GID_W-1:0]        gid;
    logic [TMR_W-1:0]        timer;

    logic                    alloc;
    logic                    pop;
    logic                    rel_in_range;
    logic                    rel_ok;
    logic                    trig;
    logic [TOTAL_PBS_NB-1:0] alloc_mask;
    logic [TOTAL_PBS_NB-1:0] rel_mask;
    logic [TOTAL_PBS_NB-1:0] pop_mask;

    function automatic logic [PID_W-1:0] ptr_inc(input logic [PID_W-1:0] p);
        return (p == PID_W'(TOTAL_PBS_NB - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [GID_W-1:0] gid_inc(input logic [GID_W-1:0] g);
        return (g == GID_W'(GRAM_NB - 1)) ? '0 : g + 1'b1;
    endfunction

    assign req_rdy = |free_map;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        req_pid = '0;
        for (int i = TOTAL_PBS_NB - 1; i >= 0; i--) begin
            if (free_map[i]) req_pid = PID_W'(i);
        end
    end

    assign alloc        = req_vld & req_rdy;
    assign pop          = bid_vld & bid_rdy;
    assign rel_in_range = (32'(rel_pid) < 32'(TOTAL_PBS_NB));
    // Only an allocated slot that has already left the pending queue may be released.
    assign rel_ok       = rel_vld & rel_in_range & ~free_map[rel_pid] & ~pend_map[rel_pid];

    always_comb begin
        alloc_mask = '0;
        rel_mask   = '0;
        pop_mask   = '0;
        if (alloc)  alloc_mask[req_pid] = 1'b1;
        if (rel_ok) rel_mask[rel_pid]   = 1'b1;
        if (pop)    pop_mask[bid_pid]   = 1'b1;
    end

    assign bid_pid  = fifo_mem[rd_ptr];
    assign bid_gid  = gid;
    assign bid_last = bid_vld & (pos == bsize - CNT_W'(1));

    assign trig = (pend_cnt >= CNT_W'(BATCH_PBS_NB)) ||
                  ((pend_cnt != '0) && ((timer == TMR_W'(TIMEOUT)) || flush));

    // NOTE: the queue storage carries no reset; the pointers and pend_cnt define what is valid.
    always_ff @(posedge clk) begin
        if (alloc) fifo_mem[wr_ptr] <= req_pid;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            free_map <= '1;
            pend_map <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            free_cnt <= CNT_W'(TOTAL_PBS_NB);
            pend_cnt <= '0;
            rel_err  <= 1'b0;
        end else begin
            // Allocation sees the pre-release bitmap, so a slot freed now is not reused now.
            free_map <= (free_map & ~alloc_mask) | rel_mask;
            pend_map <= (pend_map | alloc_mask) & ~pop_mask;
            if (alloc) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            free_cnt <= free_cnt - CNT_W'(alloc) + CNT_W'(rel_ok);
            pend_cnt <= pend_cnt + CNT_W'(alloc) - CNT_W'(pop);
            rel_err  <= rel_vld & ~rel_ok;
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state   <= IDLE;
            bid_vld <= 1'b0;
            bsize   <= '0;
            pos     <= '0;
            gid     <= '0;
            timer   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig) begin
                        state   <= ISSUE;
                        bid_vld <= 1'b1;
                        bsize   <= (pend_cnt >= CNT_W'(BATCH_PBS_NB)) ? CNT_W'(BATCH_PBS_NB) : pend_cnt;
                        pos     <= '0;
                        gid     <= '0;
                        timer   <= '0;
                    end else if (pend_cnt == '0) begin
                        timer <= '0;
                    end else if (timer != TMR_W'(TIMEOUT)) begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ISSUE: begin
                    if (bid_rdy) begin
                        if (bid_last) begin
                            state   <= WAIT_DONE;
                            bid_vld <= 1'b0;
                        end else begin
                            pos <= pos + CNT_W'(1);
                            gid <= gid_inc(gid);
                        end
                    end
                end
                WAIT_DONE: begin
                    if (batch_done) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    bid_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pep_batch_sched.md
PEP_BATCH_SCHED -- requirements
Module: pep_batch_sched

Interface
REQ-001 SHALL have parameter TOTAL_PBS_NB, default 27: number of PBS slots stored in HPU.
REQ-002 SHALL have parameter BATCH_PBS_NB, default 18: maximum PBS per batch, at most TOTAL_PBS_NB.
REQ-003 SHALL have parameter GRAM_NB, default 3: number of GRAM banks; gid is assigned round-robin over these.
REQ-004 SHALL have parameter TIMEOUT, default 64: idle cycles before a partial batch is issued.
REQ-005 SHALL derive PID_W = clog2(TOTAL_PBS_NB) (5), GID_W = clog2(GRAM_NB) (2), CNT_W = clog2(TOTAL_PBS_NB+1) (5).
REQ-006 SHALL have port clk  in  1: the single clock.
REQ-007 SHALL have port a_rst  in  1: asynchronous, active-high reset.
REQ-008 SHALL have port req_vld  in  1: a requester asks for a PBS slot.
REQ-009 SHALL have port req_rdy  out  1: a slot is available.
REQ-010 SHALL have port req_pid  out  PID_W: the allocated slot id, valid with req_rdy.
REQ-011 SHALL have ports bid_vld out 1, bid_rdy in 1, bid_pid out PID_W, bid_gid out GID_W, bid_last out 1: the batch stream to the PBS pipe.
REQ-012 SHALL have port batch_done  in  1: one-cycle pulse when the in-flight batch has completed.
REQ-013 SHALL have ports rel_vld in 1, rel_pid in PID_W: slot release.
REQ-014 SHALL have port flush  in  1: issue pending work without waiting for the timeout.
REQ-015 SHALL have ports free_cnt out CNT_W, pend_cnt out CNT_W, rel_err out 1 (one-cycle pulse).

Function
REQ-016 SHALL track slot state in a TOTAL_PBS_NB-bit free bitmap.
REQ-017 SHALL drive req_rdy = 1 whenever any slot is free.
REQ-018 SHALL drive req_pid = the lowest-index free slot.
REQ-019 SHALL, on req_vld & req_rdy, clear that slot's free bit and push req_pid into the pending FIFO (depth TOTAL_PBS_NB, in allocation order).
REQ-020 SHALL, on rel_vld with rel_pid allocated and not pending, set the free bit on the next cycle.
REQ-021 SHALL ignore any other release (slot already free, still pending, or pid >= TOTAL_PBS_NB) and pulse rel_err.
REQ-022 SHALL, on simultaneous allocate and release, apply both; allocation uses the bitmap from before the release, so a slot freed this cycle is not reallocated this cycle.
REQ-023 SHALL implement FSM IDLE -> ISSUE -> WAIT_DONE -> IDLE, allowing one batch in flight (BATCH_NB = 1).
REQ-024 SHALL, in IDLE, increment the timer while pend_cnt > 0, saturating at TIMEOUT; the timer is 0 whenever pend_cnt = 0.
REQ-025 SHALL leave IDLE for ISSUE when pend_cnt >= BATCH_PBS_NB, or pend_cnt > 0 with (timer = TIMEOUT or flush).
REQ-026 SHALL, on the IDLE -> ISSUE transition, latch bsize = min(pend_cnt, BATCH_PBS_NB) and clear the position counter and timer.
REQ-027 SHALL, in ISSUE, drive bid_vld = 1 with: bid_pid = FIFO head, bid_gid = position mod GRAM_NB, bid_last = (position = bsize-1).
REQ-028 SHALL, on each bid handshake, pop the FIFO and increment the position; the handshake with bid_last goes to WAIT_DONE.
REQ-029 SHALL hold bid_pid, bid_gid and bid_last stable while bid_vld & !bid_rdy.
REQ-030 SHALL, in WAIT_DONE, go to IDLE on batch_done; batch_done in any other state is ignored.
REQ-031 SHALL keep accepting allocations in every state; pushes during ISSUE do not change the latched bsize.
REQ-032 SHALL report pend_cnt and free_cnt as registered values.
REQ-033 SHALL keep free_cnt + pend_cnt + (allocated non-pending count) = TOTAL_PBS_NB at all times.
REQ-034 SHALL make evaluation of the first ISSUE beat registered: the first bid_vld appears 1 cycle after the trigger condition.

Reset
REQ-035 SHALL, on a_rst, go to IDLE with all slots free and the FIFO empty.
REQ-036 SHALL, on a_rst, reset outputs to: free_cnt = TOTAL_PBS_NB, pend_cnt = 0, timer = 0, req_rdy = 1, req_pid = 0, bid_vld = 0, bid_last = 0, rel_err = 0.
REQ-037 SHALL, on a_rst asserted mid-ISSUE, abandon the batch: bid_vld = 0 asynchronously and no further beats.

Verification
REQ-038 SHALL cover: 20 back-to-back allocations -> pids 0..19; batch of 18 with gid 0,1,2 repeating; bid_last on pid 17; pend_cnt = 2 after the batch.
REQ-039 SHALL cover: 5 allocations then idle -> batch issued after timer reaches 64, bsize = 5, bid_last on the 5th beat; flush issues it the next cycle instead.
REQ-040 SHALL cover: allocate 27 -> req_rdy = 0; release pid 4 -> req_rdy = 1 next cycle with req_pid = 4.
REQ-041 SHALL cover: release of a free slot or a pending slot -> rel_err pulses once and the bitmap is unchanged.
REQ-042 SHALL cover: bid_rdy toggled randomly during ISSUE -> outputs held stable, no beat lost; a second batch waits for batch_done.
REQ-043 SHALL cover: a_rst asserted on beat 7 of a batch -> bid_vld = 0 immediately; after reset free_cnt = 27 and req_pid = 0.
